dff_mem_16x8: RTL and testbench
===============================

Name: dff_mem_16x8

Overview:
- 16-word x 8-bit RAM built from flip-flops, in the style of the SAP-1 memory block.
- Address comes from a 4-bit memory address register (MAR) input.
- Writes are synchronous and gated by an active-low load strobe.
- Reads are combinational and gated by an active-low chip enable.
- Sits between the MAR and the 8-bit data bus of a simple 8-bit CPU datapath.

Parameters:
- ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH = 16 words.
- DATA_WIDTH, 8, word width in bits.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- mar  input  ADDR_WIDTH  word address for both read and write.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  read data.
- ce_n  input  1  active-low chip enable, i.e. output enable for data_out.
- lr_n  input  1  active-low load-RAM strobe, i.e. write enable.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Storage: array mem[0..15] of 8-bit registers. No other state.
- Reset: on a rising clk edge with rst_n=0, all 16 words are cleared to 0x00.
  - Reset has priority over a write in the same cycle.
  - The array is undefined before the first reset edge.
- Write: on a rising clk edge with rst_n=1 and lr_n=0, mem[mar] <= data_in.
  - The write is independent of ce_n.
  - Only the addressed word changes.
  - mar and data_in are sampled at the edge.
- lr_n=1: no array change.
- Read (combinational, zero cycles of latency):
  - ce_n=0: data_out = mem[mar].
  - ce_n=1: data_out = 0x00. No tri-state; the bus is muxed elsewhere.
- Read during write (ce_n=0, lr_n=0, same address):
  - Before the edge, data_out shows the old word.
  - After the edge, data_out shows data_in (the new value appears right after the edge).
- Changing mar with ce_n=0 updates data_out in the same cycle with no clock edge needed.
- Address wrap: mar is exactly ADDR_WIDTH bits; every value 0..15 is valid; no out-of-range case.
- Reset mid-operation: asserting rst_n=0 while lr_n=0 clears the array and drops the write.
- With ce_n=0 during reset, data_out reads 0x00 after the reset edge.
- Both strobes high: data_out = 0x00 and memory holds.
- Outputs carry no X once reset has been applied, for any input combination.

Test Plan:
- Reset clear:
  - Write 0xFF to addresses 0..15.
  - Hold rst_n=0 for 1 edge, then release.
  - ce_n=0, sweep mar 0..15 -> data_out = 0x00 at every address.
- Write/read sweep:
  - For a=0..15, lr_n=0, mar=a, data_in=a*16+a (0x00, 0x11, ..., 0xFF), one edge each.
  - Then lr_n=1, ce_n=0, sweep mar -> data_out = 0x00, 0x11, ..., 0xFF.
- Output gating: mem[5]=0xA5.
  - mar=5, ce_n=1 -> data_out = 0x00.
  - ce_n=0 -> data_out = 0xA5, combinationally with no edge.
  - With ce_n=0, switch mar to 6 (0x66) -> data_out = 0x66 in the same cycle.
- Read-during-write: mem[3]=0x12, ce_n=0, lr_n=0, mar=3, data_in=0x34.
  - Before the edge -> data_out = 0x12.
  - After the edge -> data_out = 0x34.
  - mem[2] and mem[4] unchanged.
- Write disabled: lr_n=1, mar=7, data_in=0x5A, 3 edges -> mem[7] keeps its prior value (0x77).
- Reset priority: rst_n=0 and lr_n=0 with mar=9, data_in=0x99, one edge.
  - Then rst_n=1, ce_n=0, mar=9 -> data_out = 0x00.

Source files
------------

// File: rtl/dff_mem_16x8.sv
// 16x8 flip-flop RAM for a SAP-1 style datapath: synchronous write strobed by lr_n,
// combinational read gated by ce_n, synchronous active-low clear of the whole array.
module dff_mem_16x8 #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mar,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ce_n,
  input  logic                  lr_n
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  // Reset wins over a coincident write; the write itself ignores ce_n.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (!lr_n) begin
      mem_q[mar] <= data_in;
    end
  end

  // Driven low rather than tri-stated when deselected; bus muxing happens upstream.
  always_comb begin
    data_out = '0;
    if (!ce_n) begin
      data_out = mem_q[mar];
    end
  end

endmodule

// File: tb/tb_dff_mem_16x8.sv
// Bench for dff_mem_16x8: directed scenarios followed by random traffic, all checked
// against an array model of the RAM kept here.
module tb_dff_mem_16x8;

  logic       clk;
  logic       rst_n;
  logic [3:0] mar;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ce_n;
  logic       lr_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ref_mem [16];

  dff_mem_16x8 #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mar     (mar),
    .data_in (data_in),
    .data_out(data_out),
    .ce_n    (ce_n),
    .lr_n    (lr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge; the model applies the same rule the RAM should, using the
  // inputs that were stable across the edge. Returns 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    end else if (!lr_n) begin
      ref_mem[mar] = data_in;
    end
    #1;
  endtask

  function automatic logic [7:0] model_out();
    return ce_n ? 8'h00 : ref_mem[mar];
  endfunction

  task automatic check(input string tag, input logic [7:0] exp);
    #1;
    n_tests++;
    assert (data_out === exp)
    else begin
      n_fail++;
      $error("FAIL %s: data_out=%h expected=%h", tag, data_out, exp);
    end
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    lr_n = 1'b0; mar = a; data_in = d;
    tick();
    lr_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ce_n = 1'b1; lr_n = 1'b1; mar = '0; data_in = '0;
    tick();
    rst_n = 1'b1;
    ce_n = 1'b0;
    for (int a = 0; a < 16; a++) begin
      mar = 4'(a);
      check("init_reset", 8'h00);
    end

    // Reset clear after filling with 0xFF
    for (int a = 0; a < 16; a++) write(4'(a), 8'hFF);
    mar = 4'd8;
    check("filled_ff", 8'hFF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      mar = 4'(a);
      check("reset_clear", 8'h00);
    end

    // Write/read sweep
    for (int a = 0; a < 16; a++) write(4'(a), 8'(a * 17));
    for (int a = 0; a < 16; a++) begin
      mar = 4'(a);
      check("sweep_read", 8'(a * 17));
    end

    // Output gating and combinational address changes
    write(4'd5, 8'hA5);
    mar = 4'd5; ce_n = 1'b1;
    check("gate_off", 8'h00);
    ce_n = 1'b0;
    check("gate_on", 8'hA5);
    mar = 4'd6;
    check("mar_switch", 8'h66);

    // Read during write
    write(4'd3, 8'h12);
    ce_n = 1'b0; lr_n = 1'b0; mar = 4'd3; data_in = 8'h34;
    check("rdw_before", 8'h12);
    tick();
    check("rdw_after", 8'h34);
    lr_n = 1'b1;
    mar = 4'd2;
    check("rdw_neigh_lo", 8'h22);
    mar = 4'd4;
    check("rdw_neigh_hi", 8'h44);

    // Write disabled
    lr_n = 1'b1; mar = 4'd7; data_in = 8'h5A;
    repeat (3) tick();
    check("no_write", 8'h77);

    // Reset beats a coincident write; ce_n low through reset
    rst_n = 1'b0; lr_n = 1'b0; ce_n = 1'b0; mar = 4'd9; data_in = 8'h99;
    tick();
    check("reset_during_ce", 8'h00);
    rst_n = 1'b1; lr_n = 1'b1;
    check("reset_priority", 8'h00);

    // Both strobes high after a fresh write
    write(4'd9, 8'hC3);
    ce_n = 1'b1;
    tick();
    check("both_high", 8'h00);
    ce_n = 1'b0;
    check("both_high_hold", 8'hC3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n   = ($urandom_range(0, 49) != 0);
      lr_n    = $urandom_range(0, 1) == 1;
      ce_n    = ($urandom_range(0, 3) == 0);
      mar     = 4'($urandom_range(0, 15));
      data_in = 8'($urandom);
      check("rand_pre", model_out());
      tick();
      check("rand_post", model_out());
      mar = 4'($urandom_range(0, 15));
      check("rand_addr", model_out());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
